// File: rtl/npu_pkg.sv
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared widths, write-back entry type and ReLU helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // Two's-complement ReLU: negative sums clamp to zero.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? '0 : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
//  Module      : wb_fifo
//  Description : DEPTH-entry FIFO, two write ports (slot0/slot1), one read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import npu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we0,
  input  logic [ENTRY_W-1:0] i_wdata0,
  input  logic               i_we1,
  input  logic [ENTRY_W-1:0] i_wdata1,
  input  logic               i_pop,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full2,
  output logic [ENTRY_W-1:0] o_head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_p1;
  logic [1:0]         n_push;

  // Slot1 is only ever written together with slot0, so it lands at wr_ptr+1.
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
  assign n_push    = {1'b0, i_we0} + {1'b0, i_we1};
  assign wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
  assign rd_ptr_d  = i_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d   = count_q + CNT_W'(n_push) - CNT_W'(i_pop);

  always_ff @(posedge i_clk) begin
    if (i_we0) mem_q[wr_ptr_q]  <= i_wdata0;
    if (i_we1) mem_q[wr_ptr_p1] <= i_wdata1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_full2 = (count_q > CNT_W'(DEPTH - 2));
  assign o_head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/conv_result_writeback.sv
// ============================================================================
//  Module      : conv_result_writeback
//  Description : Buffers up to two conv results per cycle and drains them into
//                the feature-map RAM write port. Optional RELU_WB_EN clamps
//                negative results to zero before buffering.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_result_writeback
  import npu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_valid1,
  input  logic [DATA_W-1:0] i_sum1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic              i_valid2,
  input  logic [DATA_W-1:0] i_sum2,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic              i_conv_done,
  output logic              o_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [ADDR_W-1:0] o_wr_count,
  output logic              o_overflow,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data1, data2;
  wb_entry_t         lane1, lane2, slot0, head;
  logic [ENTRY_W-1:0] head_raw;
  logic [CNT_W-1:0]  count;
  logic              full2, we0, we1, pop, fire, any_valid;

  logic              wr_en_q, overflow_q, latch_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_count_q;
  logic [DATA_W-1:0] wr_data_q;

`ifdef RELU_WB_EN
  assign data1 = relu(i_sum1);
  assign data2 = relu(i_sum2);
`else
  assign data1 = i_sum1;
  assign data2 = i_sum2;
`endif

  assign lane1 = '{addr: i_addr1, data: data1};
  assign lane2 = '{addr: i_addr2, data: data2};

  // Lane 1 always takes the first slot when present; lane 2 fills in otherwise.
  assign any_valid = i_valid1 | i_valid2;
  assign we0       = ~full2 & any_valid;
  assign we1       = ~full2 & i_valid1 & i_valid2;
  assign slot0     = i_valid1 ? lane1 : lane2;
  assign pop       = (count != '0);
  assign head      = wb_entry_t'(head_raw);

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we0    (we0),
    .i_wdata0 (slot0),
    .i_we1    (we1),
    .i_wdata1 (lane2),
    .i_pop    (pop),
    .o_count  (count),
    .o_full2  (full2),
    .o_head   (head_raw)
  );

  // Completion needs an empty FIFO with the final drain already presented and
  // no new arrivals; i_start always takes precedence.
  assign fire = latch_q & ~pop & ~we0 & ~i_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= pop;
      if (pop) begin
        wr_addr_q <= head.addr;
        wr_data_q <= head.data;
      end

      if (i_start)      wr_count_q <= '0;
      else if (wr_en_q) wr_count_q <= wr_count_q + ADDR_W'(1);

      if (i_start)                 overflow_q <= 1'b0;
      else if (any_valid & full2)  overflow_q <= 1'b1;

      if (i_start)          latch_q <= 1'b0;
      else if (fire)        latch_q <= 1'b0;
      else if (i_conv_done) latch_q <= 1'b1;

      done_q <= fire;
    end
  end

  assign o_ready    = ~full2;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_count = wr_count_q;
  assign o_overflow = overflow_q;
  assign o_done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writeback.sv
// ============================================================================
//  Module      : tb_conv_result_writeback
//  Description : Directed stimulus with a queue scoreboard for the RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_result_writeback;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start, i_valid1, i_valid2, i_conv_done;
  logic [7:0] i_sum1, i_sum2;
  logic [9:0] i_addr1, i_addr2;
  logic       o_ready, o_wr_en, o_overflow, o_done;
  logic [9:0] o_wr_addr, o_wr_count;
  logic [7:0] o_wr_data;

  always #5 clk = ~clk;

  conv_result_writeback #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (i_start),
    .i_valid1    (i_valid1),
    .i_sum1      (i_sum1),
    .i_addr1     (i_addr1),
    .i_valid2    (i_valid2),
    .i_sum2      (i_sum2),
    .i_addr2     (i_addr2),
    .i_conv_done (i_conv_done),
    .o_ready     (o_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_wr_count  (o_wr_count),
    .o_overflow  (o_overflow),
    .o_done      (o_done)
  );

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_fail = 0;
  int   cyc = 0, m_cnt = 0, exp_wr = 0;
  int   done_cnt = 0, done_cyc = -1, last_wr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] exp_data(input logic [7:0] s);
`ifdef RELU_WB_EN
    return s[7] ? 8'h00 : s;
`else
    return s;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented write must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && o_wr_en) begin
      last_wr_cyc = cyc;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: write addr 0x%0h data 0x%0h, none expected", o_wr_addr, o_wr_data);
      end else begin
        e = sbq.pop_front();
        check("sb_addr", o_wr_addr, e.a);
        check("sb_data", o_wr_data, e.d);
      end
    end
    if (!rst && o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // One clock of stimulus; called #1 after a rising edge, returns #1 after the next.
  task automatic cycle(input logic st, input logic cd,
                       input logic v1, input logic [7:0] s1, input logic [9:0] a1,
                       input logic v2, input logic [7:0] s2, input logic [9:0] a2);
    bit acc;
    int np;
    i_start = st; i_conv_done = cd;
    i_valid1 = v1; i_sum1 = s1; i_addr1 = a1;
    i_valid2 = v2; i_sum2 = s2; i_addr2 = a2;
    acc = (DEPTH - m_cnt) >= 2;
    check("ready", o_ready, acc);
    np = 0;
    if (acc) begin
      if (v1) begin sbq.push_back({a1, exp_data(s1)}); np++; end
      if (v2) begin sbq.push_back({a2, exp_data(s2)}); np++; end
    end
    if (st) exp_wr = 0;
    if (m_cnt > 0) exp_wr++;
    @(posedge clk); #1;
    m_cnt = m_cnt + np - ((m_cnt > 0) ? 1 : 0);
    i_start = 0; i_conv_done = 0; i_valid1 = 0; i_valid2 = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 8'h0, 10'h0, 0, 8'h0, 10'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr_en"},    o_wr_en,    0);
    check({tag, "_wr_addr"},  o_wr_addr,  0);
    check({tag, "_wr_data"},  o_wr_data,  0);
    check({tag, "_wr_count"}, o_wr_count, 0);
    check({tag, "_overflow"}, o_overflow, 0);
    check({tag, "_done"},     o_done,     0);
    check({tag, "_ready"},    o_ready,    1);
  endtask

  initial begin
    rst = 1; i_start = 0; i_conv_done = 0;
    i_valid1 = 0; i_sum1 = 0; i_addr1 = 0;
    i_valid2 = 0; i_sum2 = 0; i_addr2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 0;
    @(posedge clk); #1;

    // Single lane-1 result, two-edge latency to the RAM port.
    cycle(0, 0, 1, 8'h12, 10'd5, 0, 8'h0, 10'h0);
    check("lat_early", o_wr_en, 0);
    idle(1);
    check("lat_en", o_wr_en, 1);
    idle(1);
    check("single_en_off", o_wr_en, 0);
    check("single_count", o_wr_count, 1);
    check("single_hold_addr", o_wr_addr, 5);

    // Two back-to-back pairs, order 0,1,2,3.
    cycle(1, 0, 0, 8'h0, 10'h0, 0, 8'h0, 10'h0);
    cycle(0, 0, 1, 8'h01, 10'd0, 1, 8'h02, 10'd1);
    cycle(0, 0, 1, 8'h03, 10'd2, 1, 8'h04, 10'd3);
    idle(6);
    check("pairs_count", o_wr_count, 4);

    // Pairs every cycle until the FIFO refuses one (7th pair dropped).
    cycle(1, 0, 0, 8'h0, 10'h0, 0, 8'h0, 10'h0);
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 1, 8'(8'h40 + 2*i), 10'(10'h100 + 2*i), 1, 8'(8'h41 + 2*i), 10'(10'h101 + 2*i));
    check("ovf_set", o_overflow, 1);
    idle(12);
    check("ovf_held", o_overflow, 1);
    check("ovf_wr_count", o_wr_count, exp_wr);
    check("ovf_wr_count_hand", o_wr_count, 14);
    cycle(1, 0, 0, 8'h0, 10'h0, 0, 8'h0, 10'h0);
    check("ovf_cleared", o_overflow, 0);

    // Completion pulse after final drain.
    done_cnt = 0;
    cycle(0, 0, 1, 8'h31, 10'h40, 1, 8'h32, 10'h41);
    cycle(0, 1, 1, 8'h33, 10'h42, 1, 8'h34, 10'h43);
    idle(10);
    check("done_pulses", done_cnt, 1);
    check("done_timing", done_cyc, last_wr_cyc + 1);

    // Sign handling of the stored data.
    cycle(0, 0, 1, 8'h85, 10'h20, 1, 8'h7F, 10'h21);
    idle(2);
`ifdef RELU_WB_EN
    check("relu_lane2", o_wr_data, 8'h7F);
`else
    check("raw_lane2", o_wr_data, 8'h7F);
`endif
    idle(2);

    // Reset with five entries buffered.
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 1, 8'(8'h50 + i), 10'(10'h200 + 2*i), 1, 8'(8'h60 + i), 10'(10'h201 + 2*i));
    check("pre_rst_ready", o_ready, 1);
    rst = 1;
    #1;
    check_zero_outputs("midrst");
    sbq.delete();
    m_cnt = 0;
    exp_wr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    idle(6);
    check("post_rst_count", o_wr_count, 0);
    check("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/conv_result_writeback.md
Name: conv_result_writeback

Overview:
Downstream stage of the convolution engine. Accepts up to two 8-bit results per cycle, each with its 10-bit destination address, and buffers them in a small FIFO. Drains the FIFO one entry per cycle into the single write port of the output feature-map RAM (wr_en / wr_addr / data_in). Signals completion once the convolution engine reports done and every buffered result has been written.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 4
DATA_W, 8, result width; matches convolution sum width
ADDR_W, 10, RAM address width

Ports:
i_clk  input  1  clock
i_rst  input  1  reset; asynchronous, active-high
i_start  input  1  one-cycle pulse; clears done latch, write counter and overflow flag
i_valid1  input  1  lane 1 result valid
i_sum1  input  DATA_W  lane 1 result (o_sum1 of convolution engine)
i_addr1  input  ADDR_W  lane 1 destination (dest_address1)
i_valid2  input  1  lane 2 result valid
i_sum2  input  DATA_W  lane 2 result
i_addr2  input  ADDR_W  lane 2 destination
i_conv_done  input  1  convolution engine o_done
o_ready  output  1  at least 2 free FIFO slots
o_wr_en  output  1  RAM write enable
o_wr_addr  output  ADDR_W  RAM write address
o_wr_data  output  DATA_W  RAM write data
o_wr_count  output  ADDR_W  writes issued since i_start; wraps modulo 2^ADDR_W
o_overflow  output  1  sticky: a valid lane arrived while o_ready=0
o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, i_rst=1): FIFO pointers and count = 0, done latch = 0. All outputs 0 except o_ready, which is 1 (empty FIFO). Reset mid-drain discards all buffered entries with no further writes.
- FIFO entry is {addr, data}. count ranges 0..DEPTH. o_ready = (DEPTH - count >= 2), combinational from registered count.
- Push when o_ready=1:
  - Both lanes valid: lane 1 goes to wr_ptr, lane 2 to wr_ptr+1, and the pointer advances by 2.
  - One lane valid: that lane is pushed and the pointer advances by 1.
  - Pointers wrap modulo DEPTH.
- Push while o_ready=0: all valid lanes are dropped, o_overflow set to 1 and held until i_start or reset. FIFO contents are unchanged.
- Pop: every cycle count>0, the head entry is registered onto o_wr_addr/o_wr_data with o_wr_en=1 in the next cycle, and rd_ptr advances.
  - Latency: a result pushed at edge N appears on the write port after edge N+1 at the earliest; FIFO order is preserved.
  - When nothing pops, o_wr_en=0. o_wr_addr/o_wr_data hold their last values.
- Same-cycle push and pop: count_next = count + pushes - pop, with pushes in 0..2. No bypass of an empty FIFO.
- o_wr_count increments on each cycle o_wr_en is asserted.
- Done latch: set on i_conv_done=1 and cleared by i_start.
  - If i_start and i_conv_done occur in the same cycle, i_start wins.
  - Valid lanes in the same cycle as i_conv_done are still accepted.
- o_done: pulses for one cycle when done latch=1, count=0, and no write is in flight (o_wr_en was the final drain). The latch then clears, so one pulse is issued per run.
- i_start mid-run: clears only the latch, counter and flag. Buffered entries keep draining.

Optional Feature:
RELU_WB_EN
- Defined: each lane's data is passed through ReLU before the push, treating the sum as two's-complement. If bit DATA_W-1 is 1, the stored data is 0; otherwise it is unchanged.
- Undefined: data is stored unmodified.
- Addresses, handshake and timing are identical in both builds.

Decomposition:
- Package npu_pkg: DATA_W and ADDR_W constants, a wb_entry_t packed struct {addr, data}, and a relu() function used under RELU_WB_EN.
- Sub-module wb_fifo: DEPTH-entry FIFO with two write ports and one read port, exposing count, full2 (fewer than 2 free slots) and the head entry.
- Top holds the push mux, done latch, counter and output register.

Test Plan:
- Reset then i_valid1 only, sum=0x12, addr=5 -> one cycle later o_wr_en=1, o_wr_addr=5, o_wr_data=0x12; then o_wr_en=0, o_wr_count=1.
- Pairs (0x01@0, 0x02@1), (0x03@2, 0x04@3) on consecutive cycles -> writes appear on 4 consecutive cycles in order addr 0,1,2,3; o_wr_count=4.
- DEPTH=8, pairs pushed every cycle -> o_ready falls when count reaches 7 or 8. A forced pair while o_ready=0 sets o_overflow=1, and exactly the accepted entries are written.
- i_conv_done coincident with the last pair -> o_done pulses once, exactly one cycle after the final o_wr_en; no second pulse.
- Assert i_rst with 5 entries buffered -> all outputs 0 immediately, o_ready=1, no further writes.
- RELU_WB_EN defined, sum1=0x85, sum2=0x7F -> written data 0x00 and 0x7F. Without the macro -> 0x85 and 0x7F.
